// File: rtl/diag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : diag_pkg
// Description : Shared types for the diagnostics drain: diagnostic codes, the
//               buffered record layout, frame FSM states and checksum helper.
// Revision    : 1.0 - initial release
// ============================================================================
package diag_pkg;

    typedef enum logic [5:0] {
        EXPECTED              = 6'd0,
        UNEXPECTED            = 6'd1,
        VAR_NOT_EXISTS        = 6'd2,
        NAME_ALREADY_DEFINED  = 6'd3,
        ASSIGN_NON_MUTABLE    = 6'd4,
        CANNOT_CONVERT        = 6'd5,
        EXPECTED_BOOL         = 6'd6,
        UNDEFINED_FUNCTION    = 6'd7,
        WRONG_ARG_COUNT       = 6'd8,
        WRONG_ARG_TYPE        = 6'd9,
        EMPTY_BLOCK           = 6'd10,
        UNDEFINED_TYPE        = 6'd11,
        FN_ALREADY_DECLARED   = 6'd12,
        KEYWORD_OUTSIDE_LOOP  = 6'd13,
        INVALID_RETURN        = 6'd14,
        ALL_PATHS_MUST_RETURN = 6'd15,
        MODULE_DEFINED_TWICE  = 6'd16,
        UNREACHABLE_CODE      = 6'd17,
        SHADOWED_NAME         = 6'd18,
        DIVIDE_BY_ZERO        = 6'd19,
        INTERNAL_ERROR        = 6'd20
    } diag_code_t;

    typedef struct packed {
        diag_code_t  code;
        logic [15:0] start;
        logic [15:0] len;
    } diag_rec_t;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_SYNC = 4'd1,
        ST_CODE = 4'd2,
        ST_SH   = 4'd3,
        ST_SL   = 4'd4,
        ST_LH   = 4'd5,
        ST_LL   = 4'd6,
        ST_CHK  = 4'd7
    } frame_state_t;

    localparam int FRAME_LEN = 7;

    // Checksum covers every frame byte after SYNC and before CHK.
    function automatic logic [7:0] frame_chk(input diag_rec_t rec);
        return {2'b00, rec.code} ^ rec.start[15:8] ^ rec.start[7:0]
             ^ rec.len[15:8] ^ rec.len[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/diag_rec_fifo.sv
`default_nettype none
// ============================================================================
// Module      : diag_rec_fifo
// Description : Synchronous FIFO of diagnostic records with full/empty/count.
//               Full is registered-count based, so a pop never frees a slot
//               for a push in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module diag_rec_fifo
    import diag_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  diag_rec_t              wdata,
    output diag_rec_t              rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int              c_aw      = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_depth   = (c_aw + 1)'(DEPTH);
    localparam logic [c_aw:0]   c_cnt_one = (c_aw + 1)'(1);
    localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

    diag_rec_t       r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic            w_wr_en;
    logic            w_rd_en;

    assign full    = (r_count == c_depth);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rdata   = r_mem[r_rd_ptr];
    assign w_wr_en = push && !full && !clear;
    assign w_rd_en = pop && !empty && !clear;

    // Record storage; contents need no reset because empty gates every read.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; clear flushes everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/diag_frame_drain.sv
`default_nettype none
// ============================================================================
// Module      : diag_frame_drain
// Description : Buffers diagnostic records, applies the per-session error cap
//               and serialises each kept record into a 7-byte checksummed
//               frame for the host byte link.
// Revision    : 1.0 - initial release
// ============================================================================
module diag_frame_drain
    import diag_pkg::*;
#(
    parameter int         DEPTH      = 8,
    parameter int         MAX_ERRORS = 16,
    parameter logic [7:0] SYNC_BYTE  = 8'hD1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  diag_code_t  in_code,
    input  logic [15:0] in_start,
    input  logic [15:0] in_len,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [15:0] err_count,
    output logic [15:0] drop_count,
    output logic        capped,
    output logic        busy
);

    localparam int          c_cnt_w      = $clog2(DEPTH) + 1;
    localparam logic [15:0] c_max_errors = 16'(MAX_ERRORS);

    frame_state_t       r_state;
    frame_state_t       w_state_nxt;
    diag_rec_t          w_in_rec;
    diag_rec_t          w_head;
    diag_rec_t          r_frame;
    logic [7:0]         r_chk;
    logic               w_full;
    logic               w_empty;
    logic [c_cnt_w-1:0] w_count;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [15:0]        r_err_count;
    logic [15:0]        r_drop_count;

    assign w_in_rec   = '{code: in_code, start: in_start, len: in_len};
    assign in_ready   = !w_full;
    assign capped     = (r_err_count == c_max_errors);
    assign w_accept   = in_valid && in_ready && !clear;
    assign w_push     = w_accept && !capped;
    assign err_count  = r_err_count;
    assign drop_count = r_drop_count;
    assign busy       = (w_count != '0) || (r_state != ST_IDLE);

    diag_rec_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_in_rec),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Frame FSM next-state and byte mux; only IDLE suppresses out_valid.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        out_valid   = 1'b1;
        out_data    = 8'h00;
        case (r_state)
            ST_IDLE: begin
                out_valid = 1'b0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_SYNC;
                end
            end
            ST_SYNC: begin
                out_data = SYNC_BYTE;
                if (out_ready) w_state_nxt = ST_CODE;
            end
            ST_CODE: begin
                out_data = {2'b00, r_frame.code};
                if (out_ready) w_state_nxt = ST_SH;
            end
            ST_SH: begin
                out_data = r_frame.start[15:8];
                if (out_ready) w_state_nxt = ST_SL;
            end
            ST_SL: begin
                out_data = r_frame.start[7:0];
                if (out_ready) w_state_nxt = ST_LH;
            end
            ST_LH: begin
                out_data = r_frame.len[15:8];
                if (out_ready) w_state_nxt = ST_LL;
            end
            ST_LL: begin
                out_data = r_frame.len[7:0];
                if (out_ready) w_state_nxt = ST_CHK;
            end
            ST_CHK: begin
                out_data = r_chk;
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: begin
                out_valid   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (clear) begin
            w_pop       = 1'b0;
            w_state_nxt = ST_IDLE;
        end
    end

    // State register plus frame capture; checksum is computed once at pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_frame <= '0;
            r_chk   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_frame <= w_head;
                r_chk   <= frame_chk(w_head);
            end
        end
    end

    // Session counters: kept records up to the cap, then saturating drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count  <= '0;
            r_drop_count <= '0;
        end else if (clear) begin
            r_err_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_push) begin
                r_err_count <= r_err_count + 16'd1;
            end
            if (w_accept && capped && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_diag_frame_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_diag_frame_drain
// Description : Directed self-checking bench for diag_frame_drain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_diag_frame_drain;
    import diag_pkg::*;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        clear     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    diag_code_t  in_code   = EXPECTED;
    logic [15:0] in_start  = '0;
    logic [15:0] in_len    = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [15:0] err_count;
    logic [15:0] drop_count;
    logic        capped;
    logic        busy;

    int n_total  = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int byte_cnt = 0;

    always #5 clk = ~clk;

    diag_frame_drain #(
        .DEPTH      (8),
        .MAX_ERRORS (16),
        .SYNC_BYTE  (8'hD1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_start   (in_start),
        .in_len     (in_len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .err_count  (err_count),
        .drop_count (drop_count),
        .capped     (capped),
        .busy       (busy)
    );

    // Count bytes handed over on the link, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) byte_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        n_total++;
        n_fail++;
        $error("FAIL %s observed=timeout expected=byte", tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [55:0] mkframe(input logic [5:0] c, input logic [15:0] s,
                                            input logic [15:0] l);
        logic [7:0] k;
        k = {2'b00, c} ^ s[15:8] ^ s[7:0] ^ l[15:8] ^ l[7:0];
        return {8'hD1, 2'b00, c, s, l, k};
    endfunction

    task automatic push(input logic [5:0] c, input logic [15:0] s, input logic [15:0] l);
        in_code  = diag_code_t'(c);
        in_start = s;
        in_len   = l;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Receive one frame, optionally toggling out_ready; stalls recheck the byte.
    task automatic expect_frame(input logic [55:0] f, input bit toggle, input string tag);
        bit ph = 1'b1;
        for (int i = 0; i < 7; i++) begin
            int         cyc  = 0;
            bit         done = 1'b0;
            logic [7:0] eb   = f[55-8*i -: 8];
            while (!done) begin
                out_ready = toggle ? ph : 1'b1;
                ph        = ~ph;
                if (out_valid) check({tag, "_byte"}, 32'(out_data), 32'(eb));
                else if (i > 0) check({tag, "_valid"}, 32'(out_valid), 1);
                done = out_valid && out_ready;
                tick();
                cyc++;
                if (!done && cyc > 40) begin
                    fail_now({tag, "_timeout"});
                    return;
                end
            end
        end
    endtask

    initial begin
        logic [55:0] f;
        logic [5:0]  rc [10];
        logic [15:0] rs [10];
        logic [15:0] rl [10];
        int          snap;

        for (int k = 0; k < 10; k++) begin
            rc[k] = 6'(k + 1);
            rs[k] = 16'hA000 | 16'(k * 17);
            rl[k] = 16'(k * 3 + 1);
        end

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_err_count", 32'(err_count), 0);
        check("rst_drop_count", 32'(drop_count), 0);
        check("rst_capped", 32'(capped), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick();

        // Single record, no backpressure, exact latency
        out_ready = 1'b1;
        push(6'd3, 16'h0102, 16'h0004);
        check("t1_err_count", 32'(err_count), 1);
        check("t1_valid_n1", 32'(out_valid), 0);
        check("t1_busy_n1", 32'(busy), 1);
        tick();
        f = 56'hD1_03_0102_0004_04;
        for (int i = 0; i < 7; i++) begin
            check("t1_valid", 32'(out_valid), 1);
            check("t1_byte", 32'(out_data), 32'(f[55-8*i -: 8]));
            tick();
        end
        check("t1_valid_end", 32'(out_valid), 0);
        check("t1_busy_end", 32'(busy), 0);

        // Same record with out_ready toggling
        push(6'd3, 16'h0102, 16'h0004);
        expect_frame(f, 1'b1, "t2");
        check("t2_err_count", 32'(err_count), 2);

        // Fill the FIFO with the link stalled
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            in_code  = diag_code_t'(rc[k]);
            in_start = rs[k];
            in_len   = rl[k];
            in_valid = 1'b1;
            check("t3_ready_fill", 32'(in_ready), 1);
            tick();
        end
        in_code  = diag_code_t'(rc[9]);
        in_start = rs[9];
        in_len   = rl[9];
        check("t3_full", 32'(in_ready), 0);
        check("t3_err_count", 32'(err_count), 11);
        repeat (3) begin
            tick();
            check("t3_held", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        f = mkframe(rc[0], rs[0], rl[0]);
        for (int i = 0; i < 7; i++) begin
            check("t3_f0_ready", 32'(in_ready), 0);
            check("t3_f0_byte", 32'(out_data), 32'(f[55-8*i -: 8]));
            tick();
        end
        check("t3_idle_valid", 32'(out_valid), 0);
        check("t3_pop_cycle_ready", 32'(in_ready), 0);
        tick();
        check("t3_ready_after_pop", 32'(in_ready), 1);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("t3_err_count_10", 32'(err_count), 12);
        for (int k = 1; k < 10; k++) begin
            expect_frame(mkframe(rc[k], rs[k], rl[k]), 1'b0, "t3_frame");
        end
        check("t3_busy_end", 32'(busy), 0);

        // Error cap: 20 paced records, 16 kept
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t4_clr_err", 32'(err_count), 0);
        check("t4_clr_busy", 32'(busy), 0);
        out_ready = 1'b1;
        snap = byte_cnt;
        for (int k = 0; k < 20; k++) begin
            check("t4_ready", 32'(in_ready), 1);
            push(6'(k % 16 + 1), 16'(k), 16'(k + 100));
            if (k == 14) check("t4_capped_15", 32'(capped), 0);
            if (k == 15) check("t4_capped_16", 32'(capped), 1);
            repeat (7) tick();
        end
        repeat (20) tick();
        check("t4_err_count", 32'(err_count), 16);
        check("t4_capped", 32'(capped), 1);
        check("t4_drop_count", 32'(drop_count), 4);
        check("t4_bytes", 32'(byte_cnt - snap), 112);
        check("t4_busy", 32'(busy), 0);

        // clear while SH is stalled, with a coincident push
        clear = 1'b1;
        tick();
        clear = 1'b0;
        out_ready = 1'b0;
        push(6'd5, 16'hBEEF, 16'h0010);
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        tick();
        check("t5_sh_valid", 32'(out_valid), 1);
        check("t5_sh_byte", 32'(out_data), 32'h0000_00BE);
        clear = 1'b1;
        in_code  = diag_code_t'(6'd9);
        in_valid = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("t5_clr_valid", 32'(out_valid), 0);
        check("t5_clr_err", 32'(err_count), 0);
        check("t5_clr_drop", 32'(drop_count), 0);
        check("t5_clr_busy", 32'(busy), 0);
        tick();
        check("t5_clr_valid2", 32'(out_valid), 0);
        out_ready = 1'b1;
        push(6'd7, 16'h1234, 16'h5678);
        expect_frame(mkframe(6'd7, 16'h1234, 16'h5678), 1'b0, "t5");
        check("t5_err_count", 32'(err_count), 1);

        // Asynchronous reset mid-frame with records queued
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) push(rc[k], rs[k], rl[k]);
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        snap = byte_cnt;
        check("t6_valid", 32'(out_valid), 0);
        check("t6_data", 32'(out_data), 0);
        check("t6_ready", 32'(in_ready), 1);
        check("t6_err", 32'(err_count), 0);
        check("t6_drop", 32'(drop_count), 0);
        check("t6_capped", 32'(capped), 0);
        check("t6_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) tick();
        check("t6_no_bytes", 32'(byte_cnt - snap), 0);
        check("t6_idle_busy", 32'(busy), 0);
        push(6'd2, 16'hCAFE, 16'h0003);
        expect_frame(mkframe(6'd2, 16'hCAFE, 16'h0003), 1'b0, "t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
